// File: rtl/nios_system_cpu_oci_dct_packer.sv
// Producer side of the OCI compressed-trace path: packs 2-bit trace codes into a
// 15-slot buffer and hands full or flushed buffers to a valid/ready output frame.
module nios_system_cpu_oci_dct_packer #(
  parameter int CODE_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      code_valid,
  input  logic [CODE_W-1:0]         code,
  output logic                      code_ready,
  input  logic                      flush,
  input  logic                      test_ending,
  output logic [CODE_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      frm_valid,
  output logic [CODE_W*SLOTS-1:0]   frm_data,
  output logic [CNT_W-1:0]          frm_count,
  input  logic                      frm_ready,
  output logic                      test_has_ended
);

  localparam int              BUF_W = CODE_W * SLOTS;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

  logic [BUF_W-1:0] buf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             frm_valid_q;
  logic [BUF_W-1:0] frm_data_q;
  logic [CNT_W-1:0] frm_count_q;
  logic             flush_pending;
  logic             ended_q;

  logic             out_free;
  logic             blocked;
  logic             full;
  logic             empty;
  logic             ready_c;
  logic             accept;
  logic             move;
  logic [BUF_W-1:0] code_ext;
  logic [BUF_W-1:0] code_slot;

  always_comb begin
    out_free  = !frm_valid_q | frm_ready;
    blocked   = flush_pending | test_ending;
    full      = (cnt_q == FULL);
    empty     = (cnt_q == '0);
    ready_c   = !blocked & (!full | out_free);
    accept    = code_valid & ready_c;
    // A full buffer moves on its own; a blocked (flushing/draining) one moves if non-empty.
    move      = out_free & (full | (blocked & !empty));
    code_ext  = BUF_W'(code);
    code_slot = code_ext << (CODE_W * int'(cnt_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q         <= '0;
      cnt_q         <= '0;
      frm_valid_q   <= 1'b0;
      frm_data_q    <= '0;
      frm_count_q   <= '0;
      flush_pending <= 1'b0;
      ended_q       <= 1'b0;
    end else begin
      if (move) begin
        frm_data_q  <= buf_q;
        frm_count_q <= cnt_q;
        frm_valid_q <= 1'b1;
        if (accept) begin
          buf_q <= code_ext;
          cnt_q <= CNT_W'(1);
        end else begin
          buf_q <= '0;
          cnt_q <= '0;
        end
      end else begin
        if (frm_ready) frm_valid_q <= 1'b0;
        if (accept) begin
          buf_q <= buf_q | code_slot;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      // Pending flush survives until its data moves out, or drops at once if there is none.
      flush_pending <= flush | (flush_pending & !move & !empty);
      if (test_ending & empty & !frm_valid_q) ended_q <= 1'b1;
    end
  end

  assign code_ready     = ready_c;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign frm_valid      = frm_valid_q;
  assign frm_data       = frm_data_q;
  assign frm_count      = frm_count_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_nios_system_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer: fill/flush/stall/drain/reset scenarios with
// hand-derived expected buffer and frame contents.
module tb_nios_system_cpu_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frm_valid;
  logic [29:0] frm_data;
  logic [3:0]  frm_count;
  logic        frm_ready;
  logic        test_has_ended;

  int errors = 0;
  int checks = 0;
  logic [29:0] exp_buf;
  logic [29:0] exp_full;

  nios_system_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .code_valid     (code_valid),
    .code           (code),
    .code_ready     (code_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .frm_valid      (frm_valid),
    .frm_data       (frm_data),
    .frm_count      (frm_count),
    .frm_ready      (frm_ready),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [1:0] c, input logic fl,
                                input logic te, input logic rdy);
    code_valid  = v;
    code        = c;
    flush       = fl;
    test_ending = te;
    frm_ready   = rdy;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check_output("rst_count", 32'(dct_count), 32'd0);
    check_output("rst_buffer", 32'(dct_buffer), 32'd0);
    check_output("rst_frm_valid", 32'(frm_valid), 32'd0);
    check_output("rst_ended", 32'(test_has_ended), 32'd0);
    check_output("rst_code_ready", 32'(code_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // 15 codes 0,1,2,3,... fill the buffer completely
    exp_full = '0;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
      exp_full[2*i +: 2] = 2'(i % 4);
      tick();
    end
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_output("fill_count", 32'(dct_count), 32'd15);
    check_output("fill_buffer", 32'(dct_buffer), 32'h24E4_E4E4);
    check_output("fill_ready_when_free", 32'(code_ready), 32'd1);
    tick();
    check_output("fill_frm_valid", 32'(frm_valid), 32'd1);
    check_output("fill_frm_count", 32'(frm_count), 32'd15);
    check_output("fill_frm_data", 32'(frm_data), 32'(exp_full));
    check_output("fill_count_after", 32'(dct_count), 32'd0);
    tick();
    check_output("fill_frm_taken", 32'(frm_valid), 32'd0);

    // 3 codes then flush
    apply_stimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    apply_stimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    check_output("flush_ready_pre", 32'(code_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_output("flush_ready_pending", 32'(code_ready), 32'd0);
    tick();
    check_output("flush_frm_valid", 32'(frm_valid), 32'd1);
    check_output("flush_frm_count", 32'(frm_count), 32'd3);
    check_output("flush_frm_data", 32'(frm_data), 32'h1F);
    check_output("flush_count_after", 32'(dct_count), 32'd0);
    check_output("flush_ready_after", 32'(code_ready), 32'd1);

    // Stalled frame: fill 15 slots, then full buffer must hold
    exp_buf = '0;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'b1, 2'((i * 3) % 4), 1'b0, 1'b0, 1'b0);
      exp_buf[2*i +: 2] = 2'((i * 3) % 4);
      tick();
    end
    apply_stimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check_output("stall_ready_full", 32'(code_ready), 32'd0);
    check_output("stall_count", 32'(dct_count), 32'd15);
    tick();
    check_output("stall_count_hold", 32'(dct_count), 32'd15);
    check_output("stall_buffer_hold", 32'(dct_buffer), 32'(exp_buf));
    check_output("stall_frm_hold", 32'(frm_data), 32'h1F);
    check_output("stall_frm_valid", 32'(frm_valid), 32'd1);
    apply_stimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    check_output("stall_ready_release", 32'(code_ready), 32'd1);
    tick();
    check_output("reload_frm_valid", 32'(frm_valid), 32'd1);
    check_output("reload_frm_data", 32'(frm_data), 32'(exp_buf));
    check_output("reload_frm_count", 32'(frm_count), 32'd15);
    check_output("reload_count", 32'(dct_count), 32'd1);
    check_output("reload_buffer", 32'(dct_buffer), 32'd2);

    // Drain with count 5 and a stalled frame
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    check_output("drain_count5", 32'(dct_count), 32'd5);
    check_output("drain_ready", 32'(code_ready), 32'd0);
    tick();
    check_output("drain_hold_count", 32'(dct_count), 32'd5);
    check_output("drain_not_ended", 32'(test_has_ended), 32'd0);
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    tick();
    check_output("drain_frm5_valid", 32'(frm_valid), 32'd1);
    check_output("drain_frm5_count", 32'(frm_count), 32'd5);
    check_output("drain_frm5_data", 32'(frm_data), 32'h156);
    tick();
    check_output("drain_frm_gone", 32'(frm_valid), 32'd0);
    check_output("drain_not_ended2", 32'(test_has_ended), 32'd0);
    tick();
    check_output("drain_ended", 32'(test_has_ended), 32'd1);
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("drain_ended_sticky", 32'(test_has_ended), 32'd1);
    check_output("drain_ready_resumed", 32'(code_ready), 32'd1);

    // Mid-stream async reset with count 7 and a held frame
    for (int i = 0; i < 22; i++) begin
      apply_stimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_output("mid_count7", 32'(dct_count), 32'd7);
    check_output("mid_frm_valid", 32'(frm_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("arst_count", 32'(dct_count), 32'd0);
    check_output("arst_buffer", 32'(dct_buffer), 32'd0);
    check_output("arst_frm_valid", 32'(frm_valid), 32'd0);
    check_output("arst_frm_data", 32'(frm_data), 32'd0);
    check_output("arst_frm_count", 32'(frm_count), 32'd0);
    check_output("arst_ended", 32'(test_has_ended), 32'd0);
    tick();
    reset_n = 1'b1;
    apply_stimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_output("post_rst_count", 32'(dct_count), 32'd1);
    check_output("post_rst_slot0", 32'(dct_buffer), 32'd2);

    // Flush out the single code, then flush an empty buffer
    apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("one_frm_count", 32'(frm_count), 32'd1);
    check_output("one_frm_data", 32'(frm_data), 32'd2);
    tick();
    check_output("one_frm_gone", 32'(frm_valid), 32'd0);
    apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_output("empty_flush_pending", 32'(code_ready), 32'd0);
    tick();
    check_output("empty_flush_cleared", 32'(code_ready), 32'd1);
    check_output("empty_flush_no_frm", 32'(frm_valid), 32'd0);
    tick();
    check_output("empty_flush_no_frm2", 32'(frm_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
